// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin scheduler sharing one byte-wide UART transmitter between
//   N_REQ producers. Bytes are accepted over per-requester valid/ready
//   handshakes and issued on tx_valid/tx_byte. Issue is paced by the
//   transmitter's active/done status. A packet lock keyed on req_last keeps
//   the bytes of one packet contiguous on the line.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   req_valid     [N_REQ]    requester i has a byte
//   req_data      [8*N_REQ]  byte of requester i at [8i+7:8i]
//   req_last      [N_REQ]    byte closes a packet
//   req_ready     [N_REQ]    one-hot accept, only asserted in IDLE
//   grant         [N_REQ]    one-hot packet-lock owner, 0 when unlocked
//   tx_valid      transmitter dataValid
//   tx_byte       transmitter P_BYTE
//   tx_active     transmitter active
//   tx_done       transmitter done
//   busy          scheduler not in IDLE
//   err_timeout   sticky: a byte was dropped because the transmitter never started
module uart_tx_scheduler #(
    parameter int N_REQ         = 4,
    parameter int GAP_CLKS      = 0,
    parameter int START_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               tx_valid,
    output logic [7:0]         tx_byte,
    input  logic               tx_active,
    input  logic               tx_done,
    output logic               busy,
    output logic               err_timeout
);

    localparam int PW = $clog2(N_REQ);
    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS);

    typedef enum logic [2:0] {
        S_RESYNC,
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_WAIT_CLEAR
    } state_t;

    state_t           state_q;
    logic             tx_valid_q;
    logic [7:0]       tx_byte_q;
    logic [N_REQ-1:0] grant_q;
    logic             err_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    cur_q;     // index of the byte currently in flight
    logic [TW-1:0]    tocnt_q;
    logic [GW-1:0]    gapcnt_q;

    logic [PW-1:0]    owner_idx;
    logic [PW-1:0]    sel_idx;
    logic             sel_ok;
    logic [7:0]       sel_byte;

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
        if (int'(idx) == N_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Selection. A held lock restricts eligibility to the owner; otherwise
    // the scan runs from farthest to nearest offset so the nearest valid
    // requester at or after the pointer is the one left standing.
    always_comb begin
        int unsigned j;
        logic [PW-1:0] jj;
        j         = 0;
        jj        = '0;
        owner_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = PW'(i);
            end
        end
        sel_idx = owner_idx;
        sel_ok  = 1'b0;
        if (|grant_q) begin
            sel_ok = req_valid[owner_idx];
        end else begin
            for (int unsigned k = N_REQ; k > 0; k--) begin
                j  = (32'(ptr_q) + k - 1) % N_REQ;
                jj = PW'(j);
                if (req_valid[jj]) begin
                    sel_ok  = 1'b1;
                    sel_idx = jj;
                end
            end
        end
    end

    assign sel_byte = req_data[{sel_idx, 3'b000} +: 8];

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && sel_ok) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RESYNC;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= '0;
            grant_q    <= '0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
            cur_q      <= '0;
            tocnt_q    <= '0;
            gapcnt_q   <= '0;
        end else begin
            case (state_q)
                // Transmitter has no reset; wait out any frame it is still sending.
                S_RESYNC: begin
                    if (!tx_active && !tx_done) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (sel_ok) begin
                        tx_byte_q  <= sel_byte;
                        tx_valid_q <= 1'b1;
                        cur_q      <= sel_idx;
                        tocnt_q    <= '0;
                        state_q    <= S_ISSUE;
                        if (req_last[sel_idx]) begin
                            grant_q <= '0;
                            ptr_q   <= ptr_after(sel_idx);
                        end else begin
                            grant_q <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                        end
                    end
                end
                S_ISSUE: begin
                    if (tx_active) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_WAIT_DONE;
                    end else if (tocnt_q == TO_LAST) begin
                        // Transmitter never started: drop the byte and release the lock.
                        tx_valid_q <= 1'b0;
                        err_q      <= 1'b1;
                        grant_q    <= '0;
                        ptr_q      <= ptr_after(cur_q);
                        state_q    <= S_IDLE;
                    end else begin
                        tocnt_q <= tocnt_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    gapcnt_q <= '0;
                    if (tx_done) begin
                        state_q <= S_WAIT_CLEAR;
                    end
                end
                // Gap counting starts only once done has dropped.
                S_WAIT_CLEAR: begin
                    if (tx_done) begin
                        gapcnt_q <= '0;
                    end else if (gapcnt_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gapcnt_q <= gapcnt_q + 1'b1;
                    end
                end
                default: state_q <= S_RESYNC;
            endcase
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_byte     = tx_byte_q;
    assign grant       = grant_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one `uartTransmiter` instance between `N_REQ` byte producers. It accepts bytes over per-requester valid/ready handshakes and drives the transmitter's `dataValid`/`P_BYTE`. It paces issue from the transmitter's `active`/`done` status. Multi-byte packets are held together by a `last`-delimited grant lock, so bytes from different requesters never interleave inside a packet.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `GAP_CLKS`, default 0: extra idle clocks inserted after each byte, once the transmitter is clear.
- `START_TIMEOUT`, default 8: clocks in ISSUE without `tx_active` before abort.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `req_valid`  in  N_REQ  requester i has a byte.
- `req_data`  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
- `req_last`  in  N_REQ  byte is the last of a packet.
- `req_ready`  out  N_REQ  one-hot; byte i transfers on a rising edge where `req_valid[i]` and `req_ready[i]` are both 1.
- `grant`  out  N_REQ  one-hot owner of the packet lock; 0 when unlocked.
- `tx_valid`  out  1  to transmitter `dataValid`.
- `tx_byte`  out  8  to transmitter `P_BYTE`.
- `tx_active`  in  1  from transmitter `active`.
- `tx_done`  in  1  from transmitter `done`.
- `busy`  out  1  1 in any state other than IDLE.
- `err_timeout`  out  1  sticky; cleared only by `rst`.

## Operation
- States:
  - RESYNC
  - IDLE
  - ISSUE
  - WAIT_DONE
  - WAIT_CLEAR
- Reset values: state=RESYNC, `tx_valid`=0, `tx_byte`=0, `grant`=0, `err_timeout`=0, rr pointer=0, counters=0.
- RESYNC: the transmitter has no reset and may be mid-frame. Stay in RESYNC until `tx_active`=0 and `tx_done`=0, then go to IDLE.
- IDLE, selection:
  - If `grant`≠0, only the owner is eligible.
  - Otherwise, the first index with `req_valid`=1 searching pointer, pointer+1, … mod N_REQ.
- `req_ready` is combinational: 1 only for the selected index, and only in IDLE.
- IDLE, on transfer:
  - Latch `req_data[i]` into `tx_byte`.
  - Set `tx_valid`=1 and go to ISSUE.
  - If `req_last[i]`=0, set `grant`=1<<i; else set `grant`=0 and pointer=(i+1) mod N_REQ.
- ISSUE: hold `tx_valid`/`tx_byte`.
  - If `tx_active`=1: `tx_valid`←0, go to WAIT_DONE.
  - Else, if the timeout counter reaches START_TIMEOUT-1: `tx_valid`←0, `err_timeout`←1, `grant`←0, pointer←(owner+1) mod N_REQ, go to IDLE. The byte is dropped.
- WAIT_DONE: when `tx_done`=1, go to WAIT_CLEAR.
- WAIT_CLEAR: wait until `tx_done`=0 (the transmitter holds done for 2–3 clocks), then count GAP_CLKS clocks, then go to IDLE. No new `tx_valid` is issued while `tx_done`=1.
- Lock: a locked owner with `req_valid`=0 stalls the scheduler in IDLE. Other requesters are not served until the owner sends its `last` byte.
- Simultaneous requests with no lock: the lowest index at or after the pointer wins.
- `rst` mid-operation: asynchronous return to RESYNC with the reset values. The in-flight byte is abandoned by the scheduler.

## Timing
- Edge T: transfer.
- Cycle T+1: `tx_valid`=1, `tx_byte` valid.
- The transmitter samples at the end of T+1; `tx_active`=1 in T+2.
- `tx_valid`=0 from T+3.
- Next `req_ready` at the earliest 1 clock after `tx_done` falls + GAP_CLKS.
- `tx_valid` is never 1 outside ISSUE.
- `grant` is never multi-hot.

## Test plan
- Single byte, CLKS_PER_BIT=4, requester 0 sends 0xA5 with last=1: `tx_valid` is high exactly 2 cycles; the serial line shows 0,1,0,1,0,0,1,0,1,1 (LSB first, 4 clocks each); `busy` falls after done clears; `grant` stays 0.
- All 4 requesters valid with single-byte packets: bytes go out in order 0,1,2,3,0 with the pointer rotating; `req_ready` is one-hot each time.
- Requester 2 sends a 3-byte packet (0x11, 0x22, 0x33 with last) while requester 0 is continuously valid: the line carries 0x11, 0x22, 0x33 before any of requester 0's bytes; `grant`=4'b0100 until the last transfer.
- `tx_active` tied to 0, START_TIMEOUT=8: after 8 cycles in ISSUE, `tx_valid` drops, `err_timeout`=1 sticky, the lock is released, and the next requester is served.
- GAP_CLKS=3, back-to-back bytes: exactly 3 extra idle clocks appear between `tx_done` falling and the next `req_ready`.
- `rst` pulsed mid-frame: outputs reset immediately; `busy`=1 (RESYNC) until the transmitter finishes and `tx_done` clears; no `tx_valid` during RESYNC.
